// File: rtl/door_controller_pkg.sv
// Shared elevator door package: FSM state codes and width helpers.
package door_controller_pkg;

  localparam logic [1:0] CLOSED  = 2'd0;
  localparam logic [1:0] OPENING = 2'd1;
  localparam logic [1:0] OPEN    = 2'd2;
  localparam logic [1:0] CLOSING = 2'd3;

  // Width needed to hold the values 0..maxCount without wrapping (never zero).
  function automatic int countWidth(input int maxCount);
    return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/door_controller_if.sv
// Door controller signal bundle: car/button/sensor inputs and door status outputs.
interface door_controller_if;

  logic arrive;
  logic open_btn;
  logic close_btn;
  logic obstruct;
  logic T;
  logic door_open;
  logic motor_open;
  logic motor_close;
  logic door_closed;
  logic nudge;

  // Car/panel side: drives requests and sensors, observes door status.
  modport master (
    output arrive, open_btn, close_btn, obstruct, T,
    input  door_open, motor_open, motor_close, door_closed, nudge
  );

  // Controller side.
  modport slave (
    input  arrive, open_btn, close_btn, obstruct, T,
    output door_open, motor_open, motor_close, door_closed, nudge
  );

endinterface

// File: rtl/door_controller_motion_counter.sv
// Door travel position counter; done flags the last cycle of a full travel.
module door_motion_counter #(
  parameter int MOTION_CYCLES = 20,
  localparam int POS_W = $clog2(MOTION_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [POS_W-1:0] load_val,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic             done
);

  logic [POS_W-1:0] r_pos;

  // Position register: clear wins over load, load wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos <= '0;
    end else if (clr) begin
      r_pos <= '0;
    end else if (load) begin
      r_pos <= load_val;
    end else if (en) begin
      r_pos <= r_pos + POS_W'(1);
    end
  end

  assign pos  = r_pos;
  assign done = (r_pos == POS_W'(MOTION_CYCLES - 1));

endmodule

// File: rtl/door_controller.sv
// Elevator door controller: open/dwell/close sequencing with limited obstruction reversals.
module door_controller
  import door_controller_pkg::*;
#(
  parameter int MOTION_CYCLES = 20,
  parameter int MAX_REOPEN    = 3
) (
  input logic              clk,
  input logic              reset,
  door_controller_if.slave bus
);

  localparam int POS_W = $clog2(MOTION_CYCLES);
  localparam int CNT_W = countWidth(MAX_REOPEN);

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic             r_hold;
  logic [CNT_W-1:0] r_reopenCnt;
  logic [POS_W-1:0] w_pos;
  logic [POS_W-1:0] w_loadVal;
  logic             w_done;
  logic             w_clr;
  logic             w_load;
  logic             w_en;
  logic             w_openReq;
  logic             w_limit;
  logic             w_reverse;

  assign w_openReq = bus.open_btn | bus.obstruct;
  assign w_limit   = (r_reopenCnt == CNT_W'(MAX_REOPEN));
  assign w_reverse = (r_state == CLOSING) && w_openReq && !w_limit;
  // Reversing mid-close reopens from the mirrored position, so it takes as long as the close so far.
  assign w_loadVal = POS_W'(MOTION_CYCLES - 1) - w_pos;

  door_motion_counter #(
    .MOTION_CYCLES(MOTION_CYCLES)
  ) u_motion (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_clr),
    .load    (w_load),
    .load_val(w_loadVal),
    .en      (w_en),
    .pos     (w_pos),
    .done    (w_done)
  );

  // Next-state and travel-counter control; a reversal beats a coinciding close completion.
  always_comb begin
    w_nextState = r_state;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      CLOSED: begin
        if (bus.arrive || bus.open_btn) begin
          w_nextState = OPENING;
          w_clr       = 1'b1;
        end
      end
      OPENING: begin
        if (w_done) begin
          w_nextState = OPEN;
        end else begin
          w_en = 1'b1;
        end
      end
      OPEN: begin
        if (!w_openReq && (bus.T || bus.close_btn)) begin
          w_nextState = CLOSING;
          w_clr       = 1'b1;
        end
      end
      CLOSING: begin
        if (w_reverse) begin
          w_nextState = OPENING;
          w_load      = 1'b1;
        end else if (w_done) begin
          w_nextState = CLOSED;
          w_clr       = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      default: begin
        w_nextState = CLOSED;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLOSED;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Hold pulses for an open request while dwelling so the external dwell timer restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= 1'b0;
    end else begin
      r_hold <= (r_state == OPEN) && w_openReq;
    end
  end

  // Reversal count per door cycle, cleared when the door finally shuts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reopenCnt <= '0;
    end else if ((r_state == CLOSING) && (w_nextState == CLOSED)) begin
      r_reopenCnt <= '0;
    end else if (w_reverse) begin
      r_reopenCnt <= r_reopenCnt + CNT_W'(1);
    end
  end

  assign bus.door_closed = (r_state == CLOSED);
  assign bus.motor_open  = (r_state == OPENING);
  assign bus.motor_close = (r_state == CLOSING);
  assign bus.door_open   = (r_state == OPEN) && !r_hold;
  assign bus.nudge       = (r_state == CLOSING) && w_limit;

endmodule
